// File: rtl/pma_tx_pkg.sv
// Shared constants for the PMA transmit scheduler: symbol encodings,
// FSM state codes and the default symbol width.
package pma_tx_pkg;

   localparam int unsigned PMA_DATA_WIDTH = 10;

   localparam logic [9:0] COMMA_SYM = 10'b0011111010;  // K28.5 RD-
   localparam logic [9:0] SKP_SYM   = 10'b0011110100;  // K28.0
   localparam logic [9:0] TS_SYM    = 10'b0101010101;  // D10.2

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_TRAIN  = 2'd1;
   localparam logic [1:0] ST_ACTIVE = 2'd2;
   localparam logic [1:0] ST_SKP    = 2'd3;

endpackage

// File: rtl/pma_tx_scheduler_if.sv
// MAC-side word handshake into the PMA transmit scheduler.
interface pma_tx_scheduler_if #(
   parameter int unsigned DATA_WIDTH = 10
) ();

   logic [DATA_WIDTH-1:0] MAC_Data_in;
   logic                  MAC_Valid;
   logic                  MAC_Ready;

   modport master (output MAC_Data_in, output MAC_Valid, input MAC_Ready);
   modport slave  (input MAC_Data_in, input MAC_Valid, output MAC_Ready);

endinterface

// File: rtl/pma_tx_os_gen.sv
// Ordered-set symbol generator: one COMMA followed by TS or SKP fill symbols.
// The symbol for the current slot is combinational so the caller can register it.
module pma_tx_os_gen
   import pma_tx_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = PMA_DATA_WIDTH,
   parameter int unsigned TS_LEN     = 16,
   parameter int unsigned SKP_LEN    = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   input  logic                  sel_skp_i,
   output logic [DATA_WIDTH-1:0] sym_c,
   output logic                  last_c,
   output logic                  busy_o
);

   localparam int unsigned MAX_LEN = (TS_LEN > SKP_LEN) ? TS_LEN : SKP_LEN;
   localparam int unsigned SYM_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   logic [SYM_W-1:0] sym_cnt_q, sym_cnt_d;
   logic             busy_q, busy_d;
   logic             sel_q, sel_d;
   logic             sel_c;
   logic             run_c;
   logic [SYM_W-1:0] idx_c;
   logic [SYM_W-1:0] last_idx_c;

   // A start strobe produces symbol 0 in the same slot; the set then runs on its own.
   always_comb begin
      sym_cnt_d  = sym_cnt_q;
      busy_d     = busy_q;
      sel_d      = sel_q;
      sel_c      = busy_q ? sel_q : sel_skp_i;
      run_c      = busy_q | start_i;
      idx_c      = busy_q ? sym_cnt_q : '0;
      last_idx_c = sel_c ? SYM_W'(SKP_LEN - 1) : SYM_W'(TS_LEN - 1);
      last_c     = run_c && (idx_c == last_idx_c);
      sym_c      = '0;

      if (run_c) begin
         if (idx_c == '0) begin
            sym_c = DATA_WIDTH'(COMMA_SYM);
         end else if (sel_c) begin
            sym_c = DATA_WIDTH'(SKP_SYM);
         end else begin
            sym_c = DATA_WIDTH'(TS_SYM);
         end

         sel_d = sel_c;
         if (last_c) begin
            busy_d    = 1'b0;
            sym_cnt_d = '0;
         end else begin
            busy_d    = 1'b1;
            sym_cnt_d = idx_c + SYM_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sym_cnt_q <= '0;
         busy_q    <= 1'b0;
         sel_q     <= 1'b0;
      end else begin
         sym_cnt_q <= sym_cnt_d;
         busy_q    <= busy_d;
         sel_q     <= sel_d;
      end
   end

   assign busy_o = busy_q;

endmodule

// File: rtl/pma_tx_scheduler.sv
// Word-rate controller for the PMA serializer: link training, periodic SKP
// insertion and MAC data, with COMMA filler in idle slots.
module pma_tx_scheduler
   import pma_tx_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = PMA_DATA_WIDTH,
   parameter int unsigned TS_LEN       = 16,
   parameter int unsigned TS_COUNT     = 64,
   parameter int unsigned SKP_LEN      = 4,
   parameter int unsigned SKP_INTERVAL = 1180
) (
   input  logic                  Bit_Rate_Clk_10,
   input  logic                  Rst,
   input  logic                  Tx_Enable,
   pma_tx_scheduler_if.slave     mac,
   output logic [DATA_WIDTH-1:0] Data_out,
   output logic                  Ser_Data_En,
   output logic                  Link_Up,
   output logic                  Skp_Sent,
   output logic [1:0]            State
);

   localparam int unsigned OS_W  = (TS_COUNT > 1) ? $clog2(TS_COUNT) : 1;
   localparam int unsigned TMR_W = (SKP_INTERVAL > 1) ? $clog2(SKP_INTERVAL) : 1;

   logic [1:0]            state_q, state_d;
   logic [OS_W-1:0]       os_cnt_q, os_cnt_d;
   logic [TMR_W-1:0]      skp_timer_q, skp_timer_d;
   logic                  skp_pending_q, skp_pending_d;
   logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
   logic                  ser_data_en_q, ser_data_en_d;
   logic                  link_up_q, link_up_d;
   logic                  skp_sent_q, skp_sent_d;

   logic                  gen_start;
   logic                  gen_sel_skp;
   logic [DATA_WIDTH-1:0] gen_sym;
   logic                  gen_last;
   logic                  gen_busy;
   logic                  mac_ready_c;
   logic                  mac_accept_c;

   pma_tx_os_gen #(
      .DATA_WIDTH (DATA_WIDTH),
      .TS_LEN     (TS_LEN),
      .SKP_LEN    (SKP_LEN)
   ) u_os_gen (
      .clk       (Bit_Rate_Clk_10),
      .rst       (Rst),
      .start_i   (gen_start),
      .sel_skp_i (gen_sel_skp),
      .sym_c     (gen_sym),
      .last_c    (gen_last),
      .busy_o    (gen_busy)
   );

   assign mac_ready_c  = (state_q == ST_ACTIVE) && Tx_Enable && !skp_pending_q;
   assign mac_accept_c = mac_ready_c && mac.MAC_Valid;
   assign mac.MAC_Ready = mac_ready_c;

   always_comb begin
      state_d       = state_q;
      os_cnt_d      = os_cnt_q;
      skp_timer_d   = skp_timer_q;
      skp_pending_d = skp_pending_q;
      data_out_d    = '0;
      ser_data_en_d = 1'b0;
      link_up_d     = 1'b0;
      skp_sent_d    = 1'b0;
      gen_start     = 1'b0;
      gen_sel_skp   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            os_cnt_d      = '0;
            skp_timer_d   = '0;
            skp_pending_d = 1'b0;
            if (Tx_Enable) begin
               state_d = ST_TRAIN;
            end
         end

         // Training sets always complete; Tx_Enable is only honoured at a set boundary.
         ST_TRAIN: begin
            ser_data_en_d = 1'b1;
            gen_start     = !gen_busy;
            data_out_d    = gen_sym;
            if (gen_last) begin
               if (!Tx_Enable) begin
                  state_d  = ST_IDLE;
                  os_cnt_d = '0;
               end else if (os_cnt_q == OS_W'(TS_COUNT - 1)) begin
                  state_d     = ST_ACTIVE;
                  os_cnt_d    = '0;
                  skp_timer_d = '0;
               end else begin
                  os_cnt_d = os_cnt_q + OS_W'(1);
               end
            end
         end

         ST_ACTIVE: begin
            ser_data_en_d = 1'b1;
            link_up_d     = 1'b1;
            if (!Tx_Enable) begin
               state_d    = ST_IDLE;
               data_out_d = DATA_WIDTH'(COMMA_SYM);
            end else if (skp_pending_q) begin
               gen_start     = 1'b1;
               gen_sel_skp   = 1'b1;
               data_out_d    = gen_sym;
               skp_pending_d = 1'b0;
               state_d       = ST_SKP;
            end else if (mac_accept_c) begin
               data_out_d = mac.MAC_Data_in;
            end else begin
               data_out_d = DATA_WIDTH'(COMMA_SYM);
            end
         end

         ST_SKP: begin
            ser_data_en_d = 1'b1;
            link_up_d     = 1'b1;
            data_out_d    = gen_sym;
            if (gen_last) begin
               skp_sent_d = 1'b1;
               state_d    = Tx_Enable ? ST_ACTIVE : ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // SKP interval runs start-to-start, so the timer keeps counting inside SKP.
      if ((state_q == ST_ACTIVE) || (state_q == ST_SKP)) begin
         if (skp_timer_q == TMR_W'(SKP_INTERVAL - 1)) begin
            skp_timer_d   = '0;
            skp_pending_d = 1'b1;
         end else begin
            skp_timer_d = skp_timer_q + TMR_W'(1);
         end
      end
   end

   always_ff @(posedge Bit_Rate_Clk_10) begin
      if (Rst) begin
         state_q       <= ST_IDLE;
         os_cnt_q      <= '0;
         skp_timer_q   <= '0;
         skp_pending_q <= 1'b0;
         data_out_q    <= '0;
         ser_data_en_q <= 1'b0;
         link_up_q     <= 1'b0;
         skp_sent_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         os_cnt_q      <= os_cnt_d;
         skp_timer_q   <= skp_timer_d;
         skp_pending_q <= skp_pending_d;
         data_out_q    <= data_out_d;
         ser_data_en_q <= ser_data_en_d;
         link_up_q     <= link_up_d;
         skp_sent_q    <= skp_sent_d;
      end
   end

   assign Data_out    = data_out_q;
   assign Ser_Data_En = ser_data_en_q;
   assign Link_Up     = link_up_q;
   assign Skp_Sent    = skp_sent_q;
   assign State       = state_q;

endmodule

// File: tb/tb_pma_tx_scheduler.sv
// Directed bench for pma_tx_scheduler with small training/SKP parameters.
module tb_pma_tx_scheduler;

   localparam logic [31:0] COMMA = 32'h0FA;
   localparam logic [31:0] SKPS  = 32'h0F4;
   localparam logic [31:0] TSS   = 32'h155;

   logic       clk;
   logic       rst;
   logic       tx_en;
   logic [9:0] data_out;
   logic       ser_en;
   logic       link_up;
   logic       skp_sent;
   logic [1:0] state;

   int checks = 0;
   int errors = 0;

   pma_tx_scheduler_if #(.DATA_WIDTH(10)) mac_if ();

   pma_tx_scheduler #(
      .DATA_WIDTH   (10),
      .TS_LEN       (4),
      .TS_COUNT     (2),
      .SKP_LEN      (4),
      .SKP_INTERVAL (20)
   ) dut (
      .Bit_Rate_Clk_10 (clk),
      .Rst             (rst),
      .Tx_Enable       (tx_en),
      .mac             (mac_if),
      .Data_out        (data_out),
      .Ser_Data_En     (ser_en),
      .Link_Up         (link_up),
      .Skp_Sent        (skp_sent),
      .State           (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   initial begin
      logic [9:0]  word;
      logic        in_skp;
      logic [31:0] exp_d;

      rst                = 1'b1;
      tx_en              = 1'b0;
      mac_if.MAC_Valid   = 1'b0;
      mac_if.MAC_Data_in = '0;
      step();
      step();

      // Reset state
      chk("rst_data", 32'(data_out), 32'h0);
      chk("rst_en", 32'(ser_en), 32'h0);
      chk("rst_link", 32'(link_up), 32'h0);
      chk("rst_sent", 32'(skp_sent), 32'h0);
      chk("rst_state", 32'(state), 32'h0);
      chk("rst_ready", 32'(mac_if.MAC_Ready), 32'h0);

      rst = 1'b0;
      step();
      chk("idle_state", 32'(state), 32'h0);

      // Training: two sets of COMMA + 3 TS symbols
      tx_en = 1'b1;
      step();
      chk("train_entry_state", 32'(state), 32'h1);
      chk("train_entry_data", 32'(data_out), 32'h0);
      chk("train_entry_en", 32'(ser_en), 32'h0);
      for (int i = 0; i < 8; i++) begin
         step();
         chk("train_data", 32'(data_out), ((i % 4) == 0) ? COMMA : TSS);
         chk("train_en", 32'(ser_en), 32'h1);
         chk("train_link", 32'(link_up), 32'h0);
      end
      chk("active_state", 32'(state), 32'h2);

      step();
      chk("link_rise", 32'(link_up), 32'h1);
      chk("first_filler", 32'(data_out), COMMA);
      chk("first_ready", 32'(mac_if.MAC_Ready), 32'h1);

      // Continuous MAC traffic across two SKP insertions (edges 29-32 and 49-52)
      word               = 10'd1;
      mac_if.MAC_Valid   = 1'b1;
      mac_if.MAC_Data_in = word;
      for (int k = 10; k <= 52; k++) begin
         in_skp = ((k >= 29) && (k <= 32)) || ((k >= 49) && (k <= 52));
         chk("mac_ready", 32'(mac_if.MAC_Ready), in_skp ? 32'h0 : 32'h1);
         step();
         if (in_skp) begin
            exp_d = ((k == 29) || (k == 49)) ? COMMA : SKPS;
            chk("skp_data", 32'(data_out), exp_d);
            chk("skp_sent", 32'(skp_sent), ((k == 32) || (k == 52)) ? 32'h1 : 32'h0);
            chk("skp_link", 32'(link_up), 32'h1);
         end else begin
            chk("mac_data", 32'(data_out), 32'(word));
            chk("mac_sent", 32'(skp_sent), 32'h0);
            word               = word + 10'd1;
            mac_if.MAC_Data_in = word;
         end
      end

      // Idle MAC: filler, then a SKP set with Tx_Enable dropped on its 2nd symbol
      mac_if.MAC_Valid = 1'b0;
      for (int k = 53; k <= 72; k++) begin
         if (k == 71) tx_en = 1'b0;
         chk("fill_ready", 32'(mac_if.MAC_Ready), (k <= 68) ? 32'h1 : 32'h0);
         step();
         chk("fill_data", 32'(data_out), (k <= 69) ? COMMA : SKPS);
         chk("fill_sent", 32'(skp_sent), (k == 72) ? 32'h1 : 32'h0);
         chk("fill_en", 32'(ser_en), 32'h1);
      end
      chk("shutdown_state", 32'(state), 32'h0);
      step();
      chk("shutdown_data", 32'(data_out), 32'h0);
      chk("shutdown_en", 32'(ser_en), 32'h0);
      chk("shutdown_link", 32'(link_up), 32'h0);
      chk("shutdown_ready", 32'(mac_if.MAC_Ready), 32'h0);

      // Reset in the middle of training, then retrain from set 0
      tx_en = 1'b1;
      step();
      chk("retrain_state", 32'(state), 32'h1);
      step();
      chk("retrain_comma", 32'(data_out), COMMA);
      step();
      chk("retrain_ts", 32'(data_out), TSS);
      rst = 1'b1;
      step();
      chk("midrst_data", 32'(data_out), 32'h0);
      chk("midrst_en", 32'(ser_en), 32'h0);
      chk("midrst_state", 32'(state), 32'h0);
      chk("midrst_sent", 32'(skp_sent), 32'h0);
      rst = 1'b0;
      step();
      chk("restart_state", 32'(state), 32'h1);
      for (int i = 0; i < 8; i++) begin
         step();
         chk("restart_data", 32'(data_out), ((i % 4) == 0) ? COMMA : TSS);
         chk("restart_state_seq", 32'(state), (i == 7) ? 32'h2 : 32'h1);
      end
      step();
      chk("restart_link", 32'(link_up), 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
